// File: rtl/wb_unit.sv
// wb_unit: writeback stage in front of the register file.
//   Accepts completed instructions from EXU/LSU over in_valid/in_ready, holds
//   them in a single stage S1 for one cycle, then drives the register-file
//   write port and pulses retire. It also keeps a per-register count of
//   outstanding writers so IDU can detect RAW hazards.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   issue_valid/issue_rd        IDU issue of a writer to issue_rd
//   issue_block                 counter of issue_rd saturated, IDU must stall
//   q_raddr1/2, q_busy1/2       hazard queries (combinational from counters)
//   in_valid/in_ready           upstream handshake
//   in_wen/in_rd/in_sel         writeback control (sel 0 ALU,1 LOAD,2 PC+4,3 CSR)
//   in_alu/in_memdata/in_csr/in_pc, in_addr_lo/in_funct3  result sources
//   hold                        freezes S1 (debug/difftest pause)
//   rf_wen/rf_waddr/rf_wdata    register-file write port (zeroed when idle)
//   retire/retire_pc            one pulse per instruction leaving S1
module wb_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int SB_CNT_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_block,
  input  logic [ADDR_WIDTH-1:0] q_raddr1,
  input  logic [ADDR_WIDTH-1:0] q_raddr2,
  output logic                  q_busy1,
  output logic                  q_busy2,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_wen,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic [1:0]            in_sel,
  input  logic [DATA_WIDTH-1:0] in_alu,
  input  logic [DATA_WIDTH-1:0] in_memdata,
  input  logic [1:0]            in_addr_lo,
  input  logic [2:0]            in_funct3,
  input  logic [DATA_WIDTH-1:0] in_csr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic                  hold,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  retire,
  output logic [DATA_WIDTH-1:0] retire_pc
);

  localparam int                   NREG    = 2 ** ADDR_WIDTH;
  localparam logic [SB_CNT_W-1:0]  CNT_MAX = '1;

  // Byte lane select (zero-filled right shift, no wrap) then extension by load type.
  function automatic logic [DATA_WIDTH-1:0] load_extend(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            lo,
    input logic [2:0]            f3
  );
    logic [DATA_WIDTH-1:0] sh;
    sh = word >> {lo, 3'b000};
    case (f3)
      3'b000:  load_extend = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
      3'b001:  load_extend = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
      3'b100:  load_extend = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
      3'b101:  load_extend = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_wen_q;
  logic [ADDR_WIDTH-1:0] s1_rd_q;
  logic [DATA_WIDTH-1:0] s1_result_q, s1_result_d;
  logic [DATA_WIDTH-1:0] s1_pc_q;
  logic [SB_CNT_W-1:0]   cnt_q [NREG];
  logic [SB_CNT_W-1:0]   cnt_d [NREG];

  logic accept, leave, sb_inc;

  assign in_ready = !s1_valid_q || !hold;
  assign accept   = in_valid && in_ready;
  assign leave    = s1_valid_q && !hold;

  // Result is selected on the way in so S1 only stores the final value.
  always_comb begin
    case (in_sel)
      2'd0:    s1_result_d = in_alu;
      2'd1:    s1_result_d = load_extend(in_memdata, in_addr_lo, in_funct3);
      2'd2:    s1_result_d = in_pc + DATA_WIDTH'(4);
      default: s1_result_d = in_csr;
    endcase
  end

  // A simultaneous accept refills the stage as the old entry leaves.
  always_comb begin
    s1_valid_d = s1_valid_q;
    if (accept)     s1_valid_d = 1'b1;
    else if (leave) s1_valid_d = 1'b0;
  end

  // ---- stage S1 boundary ----
  always_ff @(posedge clk) begin
    if (!rst_n) s1_valid_q <= 1'b0;
    else        s1_valid_q <= s1_valid_d;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_wen_q    <= in_wen;
      s1_rd_q     <= in_rd;
      s1_result_q <= s1_result_d;
      s1_pc_q     <= in_pc;
    end
  end

  // ---- register-file write / retire ----
  assign rf_wen    = leave && s1_wen_q && (s1_rd_q != '0);
  assign rf_waddr  = rf_wen ? s1_rd_q : '0;
  assign rf_wdata  = rf_wen ? s1_result_q : '0;
  assign retire    = leave;
  assign retire_pc = leave ? s1_pc_q : '0;

  // ---- scoreboard ----
  assign issue_block = (cnt_q[issue_rd] == CNT_MAX) && (issue_rd != '0);
  assign sb_inc      = issue_valid && (issue_rd != '0) && !issue_block;
  assign q_busy1     = (q_raddr1 != '0) && (cnt_q[q_raddr1] != '0);
  assign q_busy2     = (q_raddr2 != '0) && (cnt_q[q_raddr2] != '0);

  // Issue and writeback to the same register cancel; decrement floors at zero.
  always_comb begin
    logic inc_hit, dec_hit;
    for (int i = 0; i < NREG; i++) begin
      inc_hit  = sb_inc && (issue_rd == ADDR_WIDTH'(i));
      dec_hit  = rf_wen && (s1_rd_q == ADDR_WIDTH'(i));
      cnt_d[i] = cnt_q[i];
      if (inc_hit && !dec_hit)
        cnt_d[i] = cnt_q[i] + 1'b1;
      else if (dec_hit && !inc_hit && (cnt_q[i] != '0))
        cnt_d[i] = cnt_q[i] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (!rst_n) cnt_q[i] <= '0;
      else        cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
module tb_wb_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_block;
  logic [4:0]  q_raddr1, q_raddr2;
  logic        q_busy1, q_busy2;
  logic        in_valid, in_ready, in_wen;
  logic [4:0]  in_rd;
  logic [1:0]  in_sel, in_addr_lo;
  logic [31:0] in_alu, in_memdata, in_csr, in_pc;
  logic [2:0]  in_funct3;
  logic        hold;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        retire;
  logic [31:0] retire_pc;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic        m_full;
  logic        m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_res, m_pc;
  int          m_cnt [32];

  always #5 clk = ~clk;

  wb_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .SB_CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_block(issue_block),
    .q_raddr1(q_raddr1), .q_raddr2(q_raddr2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_rd(in_rd),
    .in_sel(in_sel), .in_alu(in_alu), .in_memdata(in_memdata),
    .in_addr_lo(in_addr_lo), .in_funct3(in_funct3), .in_csr(in_csr), .in_pc(in_pc),
    .hold(hold),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .retire(retire), .retire_pc(retire_pc)
  );

  function automatic logic [31:0] ref_result(
    input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] mem,
    input logic [1:0] lo, input logic [2:0] f3, input logic [31:0] csr,
    input logic [31:0] pc);
    logic [31:0] sh;
    sh = mem >> (8 * lo);
    case (sel)
      2'd0: return alu;
      2'd2: return pc + 32'd4;
      2'd3: return csr;
      default: begin
        case (f3)
          3'b000:  return ((sh & 32'hFF) ^ 32'h80) - 32'h80;
          3'b001:  return ((sh & 32'hFFFF) ^ 32'h8000) - 32'h8000;
          3'b100:  return sh & 32'hFF;
          3'b101:  return sh & 32'hFFFF;
          default: return sh;
        endcase
      end
    endcase
  endfunction

  task automatic idle();
    rst_n = 1'b1; hold = 1'b0;
    issue_valid = 1'b0; issue_rd = 5'd0; q_raddr1 = 5'd0; q_raddr2 = 5'd0;
    in_valid = 1'b0; in_wen = 1'b0; in_rd = 5'd0; in_sel = 2'd0;
    in_alu = 32'd0; in_memdata = 32'd0; in_addr_lo = 2'd0; in_funct3 = 3'd0;
    in_csr = 32'd0; in_pc = 32'd0;
  endtask

  // Advance the model with the current inputs, then one clock; returns at negedge.
  task automatic tick();
    logic leave, rfw, inc, acc;
    leave = m_full && !hold;
    rfw   = leave && m_wen && (m_rd != 5'd0);
    inc   = issue_valid && (issue_rd != 5'd0) && (m_cnt[issue_rd] < 3);
    acc   = in_valid && (!m_full || !hold);
    if (!rst_n) begin
      m_full = 1'b0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else begin
      if (inc && !(rfw && m_rd == issue_rd)) m_cnt[issue_rd]++;
      if (rfw && !(inc && m_rd == issue_rd) && m_cnt[m_rd] > 0) m_cnt[m_rd]--;
      if (acc) begin
        m_full = 1'b1; m_wen = in_wen; m_rd = in_rd; m_pc = in_pc;
        m_res  = ref_result(in_sel, in_alu, in_memdata, in_addr_lo, in_funct3, in_csr, in_pc);
      end else if (leave) begin
        m_full = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle(); q_raddr1 = 5'd5; q_raddr2 = 5'd31; issue_rd = 5'd9;
    #1;
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_rf_wen got %b want 0", rf_wen); end
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL reset_retire got %b want 0", retire); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (q_busy1 !== 1'b0 || q_busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b%b want 00", q_busy1, q_busy2); end
    checks++; if (issue_block !== 1'b0) begin errors++; $display("FAIL reset_block got %b want 0", issue_block); end
    checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || retire_pc !== 32'd0) begin errors++; $display("FAIL reset_data got %h %h %h want 0", rf_waddr, rf_wdata, retire_pc); end
  endtask

  task automatic test_alu_write();
    idle(); issue_valid = 1'b1; issue_rd = 5'd5; tick();
    idle(); q_raddr1 = 5'd5; #1;
    checks++; if (q_busy1 !== 1'b1) begin errors++; $display("FAIL alu_busy_after_issue got %b want 1", q_busy1); end
    in_valid = 1'b1; in_wen = 1'b1; in_rd = 5'd5; in_sel = 2'd0; in_alu = 32'h1234;
    tick(); in_valid = 1'b0; #1;
    checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL alu_rf_wen got %b want 1", rf_wen); end
    checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL alu_waddr got %0d want 5", rf_waddr); end
    checks++; if (rf_wdata !== 32'h1234) begin errors++; $display("FAIL alu_wdata got %h want 00001234", rf_wdata); end
    checks++; if (retire !== 1'b1) begin errors++; $display("FAIL alu_retire got %b want 1", retire); end
    checks++; if (q_busy1 !== 1'b1) begin errors++; $display("FAIL alu_busy_during_write got %b want 1", q_busy1); end
    tick(); #1;
    checks++; if (q_busy1 !== 1'b0) begin errors++; $display("FAIL alu_busy_after_write got %b want 0", q_busy1); end
    checks++; if (rf_wen !== 1'b0 || retire !== 1'b0) begin errors++; $display("FAIL alu_drained got %b%b want 00", rf_wen, retire); end
  endtask

  task automatic test_load();
    logic [1:0]  los  [4] = '{2'd1, 2'd3, 2'd2, 2'd3};
    logic [2:0]  f3s  [4] = '{3'b000, 3'b000, 3'b101, 3'b001};
    // last case: shifted word is 0x80, whose 16-bit sign bit is clear
    logic [31:0] exps [4] = '{32'h0000007F, 32'hFFFFFF80, 32'h000080FF, 32'h00000080};
    for (int i = 0; i < 4; i++) begin
      idle(); in_valid = 1'b1; in_wen = 1'b1; in_rd = 5'd7; in_sel = 2'd1;
      in_memdata = 32'h80FF7F01; in_addr_lo = los[i]; in_funct3 = f3s[i]; in_alu = 32'hDEAD;
      tick(); in_valid = 1'b0; #1;
      checks++; if (rf_wdata !== exps[i]) begin errors++; $display("FAIL load_%0d got %h want %h", i, rf_wdata, exps[i]); end
    end
    tick();
  endtask

  task automatic test_x0_pc();
    idle(); in_valid = 1'b1; in_wen = 1'b1; in_rd = 5'd0; in_sel = 2'd2; in_pc = 32'h80000000;
    tick(); idle(); #1;
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL x0_rf_wen got %b want 0", rf_wen); end
    checks++; if (retire !== 1'b1) begin errors++; $display("FAIL x0_retire got %b want 1", retire); end
    checks++; if (retire_pc !== 32'h80000000) begin errors++; $display("FAIL x0_retire_pc got %h want 80000000", retire_pc); end
    checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin errors++; $display("FAIL x0_port_zero got %h %h want 0", rf_waddr, rf_wdata); end
    tick();
  endtask

  task automatic test_hold();
    idle(); in_valid = 1'b1; in_wen = 1'b1; in_rd = 5'd9; in_alu = 32'hCAFE;
    tick();
    hold = 1'b1; in_rd = 5'd10; in_alu = 32'hBEEF;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0 || rf_wen !== 1'b0 || retire !== 1'b0) begin
        errors++; $display("FAIL hold_full_%0d ready/wen/retire got %b%b%b want 000", k, in_ready, rf_wen, retire); end
      tick();
    end
    hold = 1'b0; in_valid = 1'b0; #1;
    checks++; if (rf_wen !== 1'b1 || rf_wdata !== 32'hCAFE || retire !== 1'b1) begin
      errors++; $display("FAIL hold_release got wen %b data %h retire %b want 1 0000cafe 1", rf_wen, rf_wdata, retire); end
    tick(); #1;
    checks++; if (retire !== 1'b0 || rf_wen !== 1'b0) begin errors++; $display("FAIL hold_single_retire got %b%b want 00", retire, rf_wen); end
    hold = 1'b1; in_valid = 1'b1; in_rd = 5'd11; in_alu = 32'h5A5A; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_empty_ready got %b want 1", in_ready); end
    tick(); in_alu = 32'h6666; #1;
    checks++; if (in_ready !== 1'b0 || retire !== 1'b0) begin errors++; $display("FAIL hold_empty_stall got %b%b want 00", in_ready, retire); end
    tick(); hold = 1'b0; in_valid = 1'b0; #1;
    checks++; if (rf_wdata !== 32'h5A5A || retire !== 1'b1) begin errors++; $display("FAIL hold_empty_drain got %h %b want 00005a5a 1", rf_wdata, retire); end
    tick(); #1;
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL hold_empty_after got %b want 0", retire); end
  endtask

  task automatic test_scoreboard();
    idle(); issue_valid = 1'b1; issue_rd = 5'd3; q_raddr2 = 5'd3;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (issue_block !== 1'b0) begin errors++; $display("FAIL sb_issue_%0d block got %b want 0", k, issue_block); end
      tick();
    end
    #1;
    checks++; if (issue_block !== 1'b1) begin errors++; $display("FAIL sb_saturated block got %b want 1", issue_block); end
    checks++; if (q_busy2 !== 1'b1) begin errors++; $display("FAIL sb_busy got %b want 1", q_busy2); end
    tick();
    issue_valid = 1'b0; in_valid = 1'b1; in_wen = 1'b1; in_rd = 5'd3; in_alu = 32'd1;
    tick(); in_valid = 1'b0; issue_valid = 1'b1; #1;
    checks++; if (rf_wen !== 1'b1 || issue_block !== 1'b1) begin errors++; $display("FAIL sb_blocked_with_write got %b%b want 11", rf_wen, issue_block); end
    tick(); issue_valid = 1'b0; #1;
    checks++; if (issue_block !== 1'b0) begin errors++; $display("FAIL sb_after_dec block got %b want 0", issue_block); end
    in_valid = 1'b1; tick(); in_valid = 1'b0; issue_valid = 1'b1; #1;
    checks++; if (rf_wen !== 1'b1 || issue_block !== 1'b0) begin errors++; $display("FAIL sb_inc_dec_setup got %b%b want 10", rf_wen, issue_block); end
    tick(); #1;
    checks++; if (issue_block !== 1'b0) begin errors++; $display("FAIL sb_inc_dec_cancel block got %b want 0", issue_block); end
    tick(); #1;
    checks++; if (issue_block !== 1'b1) begin errors++; $display("FAIL sb_refill block got %b want 1", issue_block); end
    issue_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    idle(); issue_valid = 1'b1; issue_rd = 5'd4; tick();
    idle(); in_valid = 1'b1; in_wen = 1'b1; in_rd = 5'd4; in_sel = 2'd3; in_csr = 32'd77; tick();
    idle(); rst_n = 1'b0; tick();
    rst_n = 1'b1; q_raddr1 = 5'd4; q_raddr2 = 5'd3; issue_rd = 5'd3; #1;
    checks++; if (rf_wen !== 1'b0 || retire !== 1'b0) begin errors++; $display("FAIL rstmid_wen_retire got %b%b want 00", rf_wen, retire); end
    checks++; if (q_busy1 !== 1'b0 || q_busy2 !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b%b want 00", q_busy1, q_busy2); end
    checks++; if (in_ready !== 1'b1 || issue_block !== 1'b0) begin errors++; $display("FAIL rstmid_ready_block got %b%b want 10", in_ready, issue_block); end
  endtask

  task automatic test_random();
    logic e_leave, e_rfw, e_block, e_b1, e_b2;
    for (int n = 0; n < 600; n++) begin
      rst_n       = ($urandom_range(0, 49) != 0);
      hold        = ($urandom_range(0, 3) == 0);
      in_valid    = ($urandom_range(0, 9) < 6);
      in_wen      = ($urandom_range(0, 3) != 0);
      in_rd       = 5'($urandom_range(0, 7));
      in_sel      = 2'($urandom);
      in_alu      = $urandom; in_memdata = $urandom; in_csr = $urandom; in_pc = $urandom;
      in_addr_lo  = 2'($urandom);
      in_funct3   = 3'($urandom);
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rd    = 5'($urandom_range(0, 7));
      q_raddr1    = 5'($urandom_range(0, 7));
      q_raddr2    = 5'($urandom_range(0, 7));
      #1;
      e_leave = m_full && !hold;
      e_rfw   = e_leave && m_wen && (m_rd != 5'd0);
      e_block = (issue_rd != 5'd0) && (m_cnt[issue_rd] == 3);
      e_b1    = (q_raddr1 != 5'd0) && (m_cnt[q_raddr1] != 0);
      e_b2    = (q_raddr2 != 5'd0) && (m_cnt[q_raddr2] != 0);
      checks++; if (rf_wen !== e_rfw) begin errors++; $display("FAIL rnd%0d rf_wen got %b want %b", n, rf_wen, e_rfw); end
      checks++; if (rf_waddr !== (e_rfw ? m_rd : 5'd0)) begin errors++; $display("FAIL rnd%0d rf_waddr got %0d want %0d", n, rf_waddr, e_rfw ? m_rd : 5'd0); end
      checks++; if (rf_wdata !== (e_rfw ? m_res : 32'd0)) begin errors++; $display("FAIL rnd%0d rf_wdata got %h want %h", n, rf_wdata, e_rfw ? m_res : 32'd0); end
      checks++; if (retire !== e_leave) begin errors++; $display("FAIL rnd%0d retire got %b want %b", n, retire, e_leave); end
      checks++; if (retire_pc !== (e_leave ? m_pc : 32'd0)) begin errors++; $display("FAIL rnd%0d retire_pc got %h want %h", n, retire_pc, e_leave ? m_pc : 32'd0); end
      checks++; if (in_ready !== (!m_full || !hold)) begin errors++; $display("FAIL rnd%0d in_ready got %b want %b", n, in_ready, !m_full || !hold); end
      checks++; if (issue_block !== e_block) begin errors++; $display("FAIL rnd%0d issue_block got %b want %b", n, issue_block, e_block); end
      checks++; if (q_busy1 !== e_b1) begin errors++; $display("FAIL rnd%0d q_busy1 got %b want %b", n, q_busy1, e_b1); end
      checks++; if (q_busy2 !== e_b2) begin errors++; $display("FAIL rnd%0d q_busy2 got %b want %b", n, q_busy2, e_b2); end
      tick();
    end
  endtask

  initial begin
    m_full = 1'b0; m_wen = 1'b0; m_rd = 5'd0; m_res = 32'd0; m_pc = 32'd0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    idle(); rst_n = 1'b0;
    @(negedge clk);
    tick(); tick();
    rst_n = 1'b1;
    test_reset();
    test_alu_write();
    test_load();
    test_x0_pc();
    test_hold();
    test_scoreboard();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
